// File: rtl/irq_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_timer_pkg
//  Brief    : Register map, CTRL field positions and FSM encodings for irq_timer.
//  Revision : 1.0 - initial release
// ============================================================================
package irq_timer_pkg;

    localparam int TIMER_CTRL   = 0;
    localparam int TIMER_PRESET = 1;
    localparam int TIMER_COUNT  = 2;

    localparam int EN_POS   = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int IM_POS   = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        CNT  = ST_CNT,
        INT  = ST_INT
    } state_t;

endpackage
`default_nettype wire

// File: rtl/irq_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_timer_if
//  Brief    : Bridge-side register bus plus interrupt line of the timer.
//  Revision : 1.0 - initial release
// ============================================================================
interface irq_timer_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              irq;

    modport master (output addr, we, wdata, input rdata, irq);
    modport slave  (input addr, we, wdata, output rdata, irq);
endinterface
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : irq_timer
//  Brief    : Memory-mapped countdown timer driving one CPU HWInt bit.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'd0,
    parameter int          ADDR_W     = 2
) (
    input  wire logic  clk,
    input  wire logic  reset,
    irq_timer_if.slave bus
);

    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;
    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_en;
    logic        w_im;
    logic        w_periodic;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_load;
    logic        w_dec;
    logic        w_set_flag;
    logic        w_clr_flag;
    logic        w_clr_en;
    logic        w_unused_wdata;

    assign w_en        = r_ctrl[EN_POS];
    assign w_im        = r_ctrl[IM_POS];
    assign w_periodic  = (r_ctrl[MODE_MSB:MODE_LSB] == MODE_PERIODIC);
    assign w_wr_ctrl   = bus.we && (bus.addr == ADDR_W'(TIMER_CTRL));
    assign w_wr_preset = bus.we && (bus.addr == ADDR_W'(TIMER_PRESET));
    assign w_unused_wdata = ^bus.wdata[31:4];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_set_flag  = 1'b0;
        w_clr_flag  = 1'b0;
        w_clr_en    = 1'b0;
        case (r_state)
            IDLE: if (w_en) w_state_nxt = LOAD;
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = CNT;
            end
            CNT: begin
                if (!w_en) begin
                    w_state_nxt = IDLE;
                end else if (r_count == 32'd0) begin
                    w_state_nxt = INT;
                    w_set_flag  = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            INT: begin
                if (w_periodic) begin
                    w_state_nxt = LOAD;
                    w_clr_flag  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_clr_en    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A bus write to CTRL overrides the FSM's EN clear and always drops the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= PRESET_RST;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_ctrl)      r_ctrl         <= bus.wdata[3:0];
            else if (w_clr_en)  r_ctrl[EN_POS] <= 1'b0;
            if (w_wr_preset)    r_preset       <= bus.wdata;
            if (w_load)         r_count        <= r_preset;
            else if (w_dec)     r_count        <= r_count - 32'd1;
            if (w_wr_ctrl)       r_irq_flag <= 1'b0;
            else if (w_set_flag) r_irq_flag <= 1'b1;
            else if (w_clr_flag) r_irq_flag <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        if (bus.addr == ADDR_W'(TIMER_CTRL))        bus.rdata = {28'd0, r_ctrl};
        else if (bus.addr == ADDR_W'(TIMER_PRESET)) bus.rdata = r_preset;
        else if (bus.addr == ADDR_W'(TIMER_COUNT))  bus.rdata = r_count;
    end

    assign bus.irq = w_im & r_irq_flag;

endmodule
`default_nettype wire

// File: tb/tb_irq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_timer
//  Brief    : Directed bench for irq_timer with a cycle-level behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_timer;

    localparam logic [31:0] PRESET_RST = 32'd0;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_on = 1'b0;

    irq_timer_if #(.ADDR_W(2)) bus ();

    irq_timer #(.PRESET_RST(PRESET_RST), .ADDR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: run/loaded/expired describe where the countdown is.
    logic        m_en, m_im;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    logic        m_flag;
    bit          m_busy, m_loaded, m_expired;

    always @(posedge clk) begin
        bit en_clr;
        en_clr = 1'b0;
        if (reset) begin
            m_en = 0; m_im = 0; m_mode = 0; m_flag = 0;
            m_preset = PRESET_RST; m_count = 0;
            m_busy = 0; m_loaded = 0; m_expired = 0;
        end else begin
            if (!m_busy) begin
                if (m_en) begin m_busy = 1; m_loaded = 0; end
            end else if (!m_loaded) begin
                m_count = m_preset; m_loaded = 1;
            end else if (m_expired) begin
                m_expired = 0;
                if (m_mode == 2'b01) begin m_loaded = 0; m_flag = 0; end
                else begin m_busy = 0; en_clr = 1; end
            end else if (!m_en) begin
                m_busy = 0;
            end else if (m_count == 0) begin
                m_expired = 1; m_flag = 1;
            end else begin
                m_count = m_count - 1;
            end
            if (en_clr) m_en = 0;
            if (bus.we && bus.addr == 2'd0) begin
                {m_im, m_mode, m_en} = bus.wdata[3:0];
                m_flag = 0;
            end
            if (bus.we && bus.addr == 2'd1) m_preset = bus.wdata;
        end
    end

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_irq", {31'd0, bus.irq}, {31'd0, m_flag & m_im});
            chk("model_rdata", bus.rdata, model_rd(bus.addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(name, bus.rdata, exp);
    endtask

    task automatic irq_chk(input string name, input logic exp);
        chk(name, {31'd0, bus.irq}, {31'd0, exp});
    endtask

    initial begin
        bit found;
        reset = 1'b1; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
        tick();
        cmp_on = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        irq_chk("rst_irq", 1'b0);
        rd_chk("rst_ctrl", 2'd0, 32'd0);
        rd_chk("rst_preset", 2'd1, PRESET_RST);
        rd_chk("rst_count", 2'd2, 32'd0);

        // One-shot, PRESET=5: irq rises at e0+8 and holds.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            tick();
            irq_chk("oneshot_irq", k >= 8);
        end
        rd_chk("oneshot_ctrl", 2'd0, 32'h8);
        rd_chk("oneshot_count", 2'd2, 32'd0);
        wr(2'd0, 32'd0);
        irq_chk("oneshot_clear", 1'b0);

        // Periodic, PRESET=3: one-cycle pulse every 6 cycles.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        bus.addr = 2'd2;
        for (int k = 1; k <= 20; k++) begin
            tick();
            irq_chk("periodic_irq", (k % 6) == 0);
            if (k == 2) chk("periodic_cnt3", bus.rdata, 32'd3);
            if (k == 5) chk("periodic_cnt0", bus.rdata, 32'd0);
        end
        wr(2'd0, 32'd0);
        repeat (4) tick();

        // Masked one-shot: flag sets silently, a later CTRL write clears it.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            irq_chk("mask_irq", 1'b0);
        end
        wr(2'd0, 32'h8);
        repeat (2) tick();
        irq_chk("mask_unmask", 1'b0);
        wr(2'd0, 32'd0);

        // Mid-count disable.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        bus.addr = 2'd2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.rdata == 32'd6) found = 1'b1;
        end
        chk("midcnt_reach6", {31'd0, found}, 32'd1);
        wr(2'd0, 32'd0);
        repeat (3) tick();
        rd_chk("midcnt_frozen", 2'd2, 32'd5);
        for (int k = 0; k < 20; k++) begin
            tick();
            irq_chk("midcnt_noirq", 1'b0);
        end
        wr(2'd0, 32'h9);
        tick(); tick();
        rd_chk("midcnt_reload", 2'd2, 32'd10);
        repeat (11) tick();
        irq_chk("midcnt_refire", 1'b1);
        wr(2'd0, 32'd0);

        // Reset while COUNT=2.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        repeat (4) tick();
        rd_chk("rstmid_cnt2", 2'd2, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_chk("rstmid_ctrl", 2'd0, 32'd0);
        rd_chk("rstmid_preset", 2'd1, PRESET_RST);
        rd_chk("rstmid_count", 2'd2, 32'd0);
        for (int k = 0; k < 15; k++) begin
            tick();
            irq_chk("rstmid_noirq", 1'b0);
        end

        // Bus edge cases.
        wr(2'd2, 32'h55);
        rd_chk("ro_count", 2'd2, 32'd0);
        wr(2'd3, 32'h1234);
        rd_chk("addr3_zero", 2'd3, 32'd0);
        wr(2'd0, 32'hFFFF_FFFF);
        rd_chk("ctrl_mask", 2'd0, 32'hF);
        repeat (5) tick();
        irq_chk("mode11_level", 1'b1);
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            tick();
            irq_chk("p0_irq", (k % 3) == 0);
        end
        wr(2'd0, 32'd0);
        repeat (4) tick();

        // CTRL write colliding with the one-shot INT step.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        repeat (4) tick();
        irq_chk("coll_fire", 1'b1);
        wr(2'd0, 32'h9);
        irq_chk("coll_flagclr", 1'b0);
        rd_chk("coll_ctrl", 2'd0, 32'h9);
        repeat (3) tick();
        irq_chk("coll_quiet", 1'b0);
        tick();
        irq_chk("coll_refire", 1'b1);
        wr(2'd0, 32'd0);
        repeat (2) tick();

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_timer.md
Name: irq_timer

Overview:
- Memory-mapped countdown timer. Acts as the interrupt source that drives one bit of the CPU's 6-bit HWInt vector into the coprocessor-0 interrupt logic.
- Sits on the data-memory bridge as a 3-register peripheral. The CPU programs it with sw and reads it with lw.
- Raises a level (one-shot) or pulse (periodic) interrupt request when its count expires.

Parameters:
- PRESET_RST, 32'd0, reset value of the PRESET register.
- ADDR_W, 2, width of the word-index address (0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- addr  input  ADDR_W  word index of the register being accessed (byte address [3:2])
- we  input  1  write strobe from the bridge, sampled at posedge clk
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr
- irq  output  1  interrupt request to the CPU HWInt bit

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous and active-high.
- Reset values:
  - CTRL = 0, PRESET = PRESET_RST, COUNT = 0.
  - state = IDLE, irq_flag = 0, so irq = 0.
  - Reset mid-count aborts the count immediately; no irq is produced.
- CTRL bit fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 = one-shot, 01 = periodic, 10/11 behave as 00.
  - [3] IM: interrupt mask, 1 = allow.
  - [31:4] read as 0; writes to them are ignored.
- Register access:
  - PRESET is read/write.
  - COUNT is read-only; writes to COUNT and to addr 3 are ignored.
  - Addr 3 reads as 0.
- rdata: pure combinational mux of the current register values. No read side effects.
- irq: irq = CTRL.IM & irq_flag (combinational).
- FSM states: IDLE, LOAD, CNT, INT. Transitions are evaluated on each posedge using pre-edge register values.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if !EN, go to IDLE and freeze COUNT;
    - else if COUNT == 0, go to INT and set irq_flag <= 1;
    - else COUNT <= COUNT - 1.
  - INT:
    - MODE one-shot: clear CTRL.EN, go to IDLE, irq_flag stays 1.
    - MODE periodic: go to LOAD, irq_flag <= 0.
- Timing: a CTRL write with EN=1 and PRESET=P, at write edge e0, gives irq high from edge e0+P+3.
  - One-shot: irq stays high until a CTRL write clears it.
  - Periodic: irq is a 1-cycle pulse with period P+3 cycles.
- irq_flag clearing: any CTRL write clears irq_flag, regardless of data.
- Simultaneous CTRL write and INT/FSM update:
  - The bus write to CTRL wins; the FSM's EN clear is dropped.
  - irq_flag ends cleared.
  - State still follows the FSM using the old CTRL value.
- EN cleared by write during LOAD or CNT: the FSM returns to IDLE on the next CNT evaluation. COUNT holds its value.
- PRESET write during CNT: no effect on the current COUNT; it is used at the next LOAD.
- PRESET = 0: LOAD, then CNT sees 0, then INT. Period is 3 cycles.
- Arithmetic: COUNT is a 32-bit unsigned decrement. It never wraps, because 0 is intercepted before the decrement.

Decomposition:
- Shared macros header (alongside the existing CP0 bit-position macros):
  - register word indices TIMER_CTRL, TIMER_PRESET, TIMER_COUNT;
  - CTRL bit positions EN_POS, MODE_MSB/LSB, IM_POS;
  - MODE encodings;
  - state encodings (2-bit).
- No sub-module needed. Single module: register file, FSM and read mux.

Test Plan:
- One-shot: write PRESET=5, then CTRL=0x9 (EN=1, one-shot, IM=1) at edge e0 -> irq=0 through e0+7, irq=1 from e0+8 onward. CTRL.EN reads 0, COUNT reads 0. Writing CTRL=0 clears irq on the next edge.
- Periodic: PRESET=3, CTRL=0xB -> irq pulses 1 cycle wide, first at e0+6, then every 6 cycles. COUNT reads 3,2,1,0 per period.
- Mask: one-shot with CTRL=0x1 (IM=0), PRESET=2 -> irq stays 0. Then writing CTRL=0x8 keeps irq 0, because the CTRL write clears irq_flag.
- Mid-count disable: PRESET=10, start; at COUNT=6 write CTRL=0 -> COUNT frozen at 6 or 5, state IDLE, no irq ever. Re-enable reloads 10.
- Reset mid-count: PRESET=4, start, assert reset for 1 cycle while COUNT=2 -> all registers read 0 (PRESET = PRESET_RST), irq=0, no later irq.
- Bus edge cases:
  - write COUNT=0x55 -> COUNT unchanged;
  - write CTRL=0xFFFFFFFF -> reads 0x0000000F;
  - addr 3 reads 0;
  - PRESET=0 in periodic mode -> irq pulse every 3 cycles.
